// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin code arbiter.
// Pure declarations: no logic, no latency, no flow control.
package arb_pkg;
  localparam int ARB_N_REQ  = 8;
  localparam int ARB_CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_pick8.sv
// Round-robin winner search: rotate req by ptr, find lowest set bit, un-rotate.
// Purely combinational, zero latency; no flow control.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N_REQ-1:0]  req,
  input  logic [ARB_CODE_W-1:0] ptr,
  output logic [ARB_CODE_W-1:0] win,
  output logic                  any
);
  // Doubling all but the top bit is enough to cover every rotation up to ptr=7.
  logic [2*ARB_N_REQ-2:0] dbl;
  logic [ARB_N_REQ-1:0]   rot;
  logic [ARB_CODE_W-1:0]  off;

  always_comb begin
    dbl = {req[ARB_N_REQ-2:0], req};
    rot = dbl[ptr +: ARB_N_REQ];
    off = '0;
    for (int i = ARB_N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ARB_CODE_W'(i);
    end
    win = off + ptr;
    any = |req;
  end
endmodule

// File: rtl/rr_code_arbiter.sv
// Round-robin owner of the 3-to-8 decoder code; grant 1 cycle after request, RELEASE+IDLE gap between owners.
// Grants held until done/withdrawal (or MAX_HOLD when RR_ARB_TIMEOUT_EN is defined); no preemption.
module rr_code_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ARB_N_REQ-1:0]  req,
  input  logic                  done,
  output logic [ARB_CODE_W-1:0] grant_code,
  output logic                  grant_valid,
  output logic                  busy,
  output logic                  timeout
);
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_code_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_t            state_q, state_d;
  logic [ARB_CODE_W-1:0] grant_code_q, grant_code_d;
  logic [ARB_CODE_W-1:0] ptr_q, ptr_d;
  logic                  grant_valid_q, grant_valid_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [ARB_CODE_W-1:0] pick_win;
  logic                  pick_any;
  logic                  release_now;
  logic                  hold_expired;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  assign hold_expired = (hold_cnt_q == 8'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_code_d  = grant_code_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    timeout_d     = 1'b0;
    release_now   = done | ~req[grant_code_q];
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_code_d  = pick_win;
          grant_valid_d = 1'b1;
          state_d       = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now || hold_expired) begin
          state_d       = RELEASE;
          grant_valid_d = 1'b0;
          timeout_d     = ~release_now;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      RELEASE: begin
        ptr_d   = grant_code_q + 3'd1;
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_code_q  <= '0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_code_q  <= grant_code_d;
      grant_valid_q <= grant_valid_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign grant_code  = grant_code_q;
  assign grant_valid = grant_valid_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;
endmodule
